// File: rtl/mandelbrot_iter_engine.sv
// Per-pixel Mandelbrot escape-time engine: iterates z <- z^2 + c in Q4.28 and writes the
// escape count to pixel RAM at {y,x}, flagging the end of a frame.
module mandelbrot_iter_engine #(
   parameter int unsigned MAX_ITER = 255,
   parameter int unsigned COUNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        c_re,
   input  logic [31:0]        c_im,
   input  logic [9:0]         x,
   input  logic [9:0]         y,
   input  logic               in_last,
   output logic               wr_en,
   output logic [19:0]        wr_addr,
   output logic [COUNT_W-1:0] count_out,
   output logic               frame_done
);

   typedef enum logic [1:0] {StIdle, StIter, StDone} state_t;

   // 4.0 in the Q8.56 product format
   localparam logic [64:0] MagLimit = 65'd1 << 58;

   state_t              state;
   logic signed [31:0]  cr, ci, zr, zi;
   logic [9:0]          px, py;
   logic                last_pix;
   logic [COUNT_W-1:0]  n;

   logic signed [63:0]  p_rr, p_ii, p_ri, diff;
   logic [64:0]         mag2;
   logic                escape;
   logic signed [31:0]  zr_nxt, zi_nxt;
   logic                unused_bits;

   always_comb begin
      p_rr   = 64'(zr) * 64'(zr);
      p_ii   = 64'(zi) * 64'(zi);
      p_ri   = 64'(zr) * 64'(zi);
      diff   = p_rr - p_ii;
      // Squares are non-negative, so zero-extension to 65 bits is exact.
      mag2   = {1'b0, p_rr} + {1'b0, p_ii};
      escape = (mag2 > MagLimit) || (n == COUNT_W'(MAX_ITER));
      zr_nxt = diff[59:28] + cr;
      // (2*zr*zi)[59:28] is zr*zi[58:27]; a plain bit select floors toward -inf.
      zi_nxt = p_ri[58:27] + ci;
   end

   assign unused_bits = ^{diff[63:60], diff[27:0], p_ri[63:59], p_ri[26:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         in_ready   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         count_out  <= '0;
         frame_done <= 1'b0;
         cr         <= '0;
         ci         <= '0;
         zr         <= '0;
         zi         <= '0;
         px         <= '0;
         py         <= '0;
         last_pix   <= 1'b0;
         n          <= '0;
      end else if (en) begin
         unique case (state)
            StIdle: begin
               if (!in_ready) begin
                  in_ready <= 1'b1;
               end else if (in_valid) begin
                  cr         <= c_re;
                  ci         <= c_im;
                  px         <= x;
                  py         <= y;
                  last_pix   <= in_last;
                  zr         <= '0;
                  zi         <= '0;
                  n          <= '0;
                  frame_done <= 1'b0;
                  in_ready   <= 1'b0;
                  state      <= StIter;
               end
            end
            StIter: begin
               if (escape) begin
                  count_out <= n;
                  wr_addr   <= {py, px};
                  wr_en     <= 1'b1;
                  state     <= StDone;
               end else begin
                  zr <= zr_nxt;
                  zi <= zi_nxt;
                  n  <= n + 1'b1;
               end
            end
            StDone: begin
               wr_en    <= 1'b0;
               in_ready <= 1'b1;
               state    <= StIdle;
               if (last_pix) frame_done <= 1'b1;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Directed self-checking bench for mandelbrot_iter_engine with hand-computed escape counts.
module tb_mandelbrot_iter_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] c_re = '0;
   logic [31:0] c_im = '0;
   logic [9:0]  x = '0;
   logic [9:0]  y = '0;
   logic        in_last = 1'b0;
   logic        wr_en;
   logic [19:0] wr_addr;
   logic [7:0]  count_out;
   logic        frame_done;

   int n_checks = 0;
   int n_pass = 0;
   int writes = 0;
   logic wr_prev = 1'b0;
   time t_acc;

   localparam logic [31:0] One     = 32'h1000_0000;
   localparam logic [31:0] OneHalf = 32'h1800_0000;
   localparam logic [31:0] NegTwo  = 32'hE000_0000;

   mandelbrot_iter_engine #(.MAX_ITER(255), .COUNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .c_re       (c_re),
      .c_im       (c_im),
      .x          (x),
      .y          (y),
      .in_last    (in_last),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .count_out  (count_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Count distinct write strobes (a stalled, held strobe is one write).
   always @(negedge clk) begin
      if (wr_en && !wr_prev) writes++;
      wr_prev = wr_en;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
      check_eq({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      check_eq({tag, "_addr"}, 32'(wr_addr), 32'd0);
      check_eq({tag, "_count"}, 32'(count_out), 32'd0);
      check_eq({tag, "_frame"}, 32'(frame_done), 32'd0);
   endtask

   task automatic wait_ready(input string tag);
      int g = 0;
      while (!in_ready && g < 20) begin
         @(posedge clk); #1;
         g++;
      end
      check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
   endtask

   // Present one pixel, then check write latency, data, address and the return to idle.
   task automatic do_pixel(input string tag, input logic [31:0] cre, input logic [31:0] cim,
                           input logic [9:0] px, input logic [9:0] py, input logic lst,
                           input int exp_n, input bit hold);
      int cyc;
      c_re = cre; c_im = cim; x = px; y = py; in_last = lst; in_valid = 1'b1;
      wait_ready(tag);
      @(posedge clk); t_acc = $time; #1;
      if (!hold) in_valid = 1'b0;
      check_eq({tag, "_busy"}, 32'(in_ready), 32'd0);
      check_eq({tag, "_fd_clr"}, 32'(frame_done), 32'd0);
      cyc = 0;
      while (!wr_en && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq({tag, "_lat"}, 32'(cyc), 32'(exp_n + 1));
      check_eq({tag, "_count"}, 32'(count_out), 32'(exp_n));
      check_eq({tag, "_addr"}, 32'(wr_addr), 32'({py, px}));
      @(posedge clk); #1;
      check_eq({tag, "_wr_drop"}, 32'(wr_en), 32'd0);
      check_eq({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
      check_eq({tag, "_frame"}, 32'(frame_done), 32'(lst));
      check_eq({tag, "_count_hold"}, 32'(count_out), 32'(exp_n));
   endtask

   initial begin
      time t1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst = 1'b0;
      #1;
      check_eq("rst_rel_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check_eq("first_ready", 32'(in_ready), 32'd1);

      // Orbit 0, 1, 2, 5 -> count 3 at {3,5}
      do_pixel("c1", One, 32'd0, 10'd5, 10'd3, 1'b0, 3, 1'b0);
      // |z|^2 = 4.5 after the first step -> count 1
      do_pixel("c15", OneHalf, OneHalf, 10'd7, 10'd1, 1'b0, 1, 1'b0);
      do_pixel("c0", 32'd0, 32'd0, 10'd1023, 10'd1023, 1'b0, 255, 1'b0);
      // |z|^2 == 4 exactly forever: strict compare must not escape
      do_pixel("cm2", NegTwo, 32'd0, 10'd0, 10'd512, 1'b0, 255, 1'b0);

      // Back-to-back with in_valid held; accepts exactly count+3 edges apart
      do_pixel("bb1", OneHalf, OneHalf, 10'd10, 10'd20, 1'b0, 1, 1'b1);
      t1 = t_acc;
      do_pixel("bb2", One, 32'd0, 10'd11, 10'd20, 1'b1, 3, 1'b1);
      check_eq("bb_spacing", 32'((t_acc - t1) / 10), 32'd4);
      in_valid = 1'b0;
      check_eq("bb_frame_hold", 32'(frame_done), 32'd1);
      do_pixel("fd_clear", One, 32'd0, 10'd1, 10'd2, 1'b0, 3, 1'b0);

      // Reset mid-iteration aborts the pixel
      c_re = '0; c_im = '0; x = 10'd9; y = 10'd9; in_last = 1'b1; in_valid = 1'b1;
      wait_ready("rmid");
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("rmid");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_outputs("rmid_rel");
      @(posedge clk); #1;
      check_eq("rmid_ready", 32'(in_ready), 32'd1);
      do_pixel("post_rst", OneHalf, OneHalf, 10'd2, 10'd4, 1'b0, 1, 1'b0);

      // en stalls: 4 cycles mid-ITER, 4 cycles during DONE
      c_re = One; c_im = '0; x = 10'd6; y = 10'd8; in_last = 1'b0; in_valid = 1'b1;
      wait_ready("stall");
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      en = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("stall_e7_wr", 32'(wr_en), 32'd0);
      @(posedge clk); #1;
      check_eq("stall_e8_wr", 32'(wr_en), 32'd1);
      check_eq("stall_count", 32'(count_out), 32'd3);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_eq("stall_done_wr", 32'(wr_en), 32'd1);
         check_eq("stall_done_addr", 32'(wr_addr), 32'({10'd8, 10'd6}));
      end
      en = 1'b1;
      @(posedge clk); #1;
      check_eq("stall_wr_drop", 32'(wr_en), 32'd0);
      check_eq("stall_ready", 32'(in_ready), 32'd1);
      check_eq("stall_count_hold", 32'(count_out), 32'd3);

      repeat (2) @(posedge clk);
      #1;
      check_eq("write_total", 32'(writes), 32'd9);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
